wb_led_pwm_array: RTL
=====================

Name: wb_led_pwm_array

Overview:
- Parametrised Wishbone-slave LED driver with NUM_LED channels; each channel has its own PWM duty cycle, replacing plain on/off LED pins with dimmable outputs.
- Connects to the NoC Wishbone bus the same way as the other peripheral slaves.
- Contains its own bus handshake FSM, a register file, a shared prescaler and PWM counter, glitch-free shadowed duty updates, and a registered output stage.

Parameters:
- NUM_LED, 32: number of LED channels, legal range 1..32.
- PWM_BITS, 8: PWM counter and duty width, legal range 2..16.
- PRESC_W, 16: prescaler register width.

Ports:
- clk_i, input, 1: system clock.
- rst_n_i, input, 1: asynchronous active-low reset.
- wb_adr_i, input, 32: byte address; only [7:2] are decoded.
- wb_dat_i, input, 32: write data.
- wb_sel_i, input, 4: byte enables.
- wb_we_i, input, 1: 1 = write, 0 = read.
- wb_cyc_i, input, 1: bus cycle valid.
- wb_stb_i, input, 1: strobe.
- wb_dat_o, output, 32: read data, valid while wb_ack_o=1.
- wb_ack_o, output, 1: transfer acknowledge.
- led_pins, output, NUM_LED: PWM outputs, 1 = LED on.

Behaviour:
- Reset, asynchronous on rst_n_i=0:
  - All registers, both counters and the shadow duty registers are cleared.
  - Outputs: wb_ack_o=0, wb_dat_o=0, led_pins=0.
- Register map, decoded on wb_adr_i[7:2]:
  - 0x00 CTRL (RW): bit0 EN (global enable), bit1 INV (invert all outputs); other bits read as 0.
  - 0x04 PRESC (RW, [PRESC_W-1:0]): PWM tick occurs every PRESC+1 clocks.
  - 0x08 STATUS (RO): [PWM_BITS-1:0] = current pwm_cnt; bit31 = update pending.
  - 0x40 + 4*i, i < NUM_LED: DUTY[i] (RW, [PWM_BITS-1:0]). Reads return the written value, not the shadow copy.
  - Unmapped addresses, including DUTY indices >= NUM_LED: reads return 0, writes are ignored, and ack is still given.
- Handshake FSM, states IDLE → ACK → IDLE:
  - IDLE: if wb_cyc_i & wb_stb_i, go to ACK and drive wb_ack_o=1 on the next clock. Latency is exactly 1 cycle.
  - ACK: wb_ack_o=1 for exactly one cycle, then return to IDLE. A strobe is never acknowledged twice; back-to-back transfers therefore complete at most one per 2 cycles.
  - Writes commit at the IDLE→ACK edge using the values sampled in IDLE. Each byte lane is written only if its wb_sel_i bit is 1; register bits beyond the register width are dropped.
  - Reads: wb_dat_o is loaded at the same edge, is valid while ack=1, and returns to 0 in IDLE.
  - If cyc or stb drops in IDLE, nothing happens. If it drops while in ACK, the FSM still returns to IDLE with no side effect beyond the already committed write.
- Prescaler:
  - While EN=1, presc_cnt increments each clock. When presc_cnt==PRESC it wraps to 0 and issues a 1-cycle tick.
  - PRESC=0 gives a tick every clock.
  - Writing PRESC below the current presc_cnt forces a wrap on the next clock; there is no 2^PRESC_W stall.
- PWM counter:
  - On each tick, pwm_cnt increments, wrapping from 2^PWM_BITS-1 to 0. The wrap tick is the "period boundary".
- Shadow duty:
  - A DUTY write sets the pending flag.
  - At the period boundary, every shadow_duty[i] is loaded from DUTY[i] and pending is cleared.
  - If a DUTY write and a boundary occur in the same cycle, the write is visible at the next boundary and pending stays set.
- Output:
  - raw[i] = (pwm_cnt < shadow_duty[i]), except shadow_duty[i] = 2^PWM_BITS-1 forces raw[i]=1 (full on).
  - led_pins[i] = EN ? (raw[i] ^ INV) : 0.
  - Registered: 1 clock after counter change.
- EN cleared:
  - presc_cnt and pwm_cnt are held at 0, led_pins go to 0 next clock, and shadow duties are loaded immediately from DUTY.
  - Setting EN restarts the period from pwm_cnt=0.
- Reset mid-transfer: ack drops at once and the FSM goes to IDLE; the master must retry.

Test Plan:
- Reset check: reset, then read 0x00, 0x04, 0x08, 0x40 → each returns 0x0 with ack exactly 1 cycle after stb; led_pins=0.
- Byte-lane write: write 0x04=0x0000_0003 with sel=4'b0001, then write 0x04=0xFFFF_FF00 with sel=4'b0010 → read 0x04 returns 0x0000_FF03.
- PWM duty: PRESC=0, DUTY[0]=64, DUTY[1]=255, CTRL=1 → over 256 clocks, led_pins[0] is high 64 clocks and led_pins[1] is high all 256; led_pins[2]=0.
- Shadow update: with a period running, write DUTY[0]=200 at pwm_cnt=10 → STATUS bit31=1; old duty holds until pwm_cnt wraps to 0, then high time becomes 200 and bit31=0.
- Inversion and edge cases: CTRL=3 with DUTY[3]=0 → led_pins[3]=1 constantly. Write 0x30 (unmapped) → ack, and a read returns 0.
- Handshake robustness: hold stb=1 continuously for 6 cycles → ack pattern 0,1,0,1,0,1 (one ack per transfer). Assert reset during ACK → ack=0 immediately.

Source files
------------

// File: rtl/wb_led_pwm_array.sv
// Wishbone-slave LED driver: NUM_LED dimmable channels sharing one prescaler and PWM counter,
// with per-channel duty registers shadowed at the PWM period boundary.
module wb_led_pwm_array #(
    parameter int NUM_LED  = 32,
    parameter int PWM_BITS = 8,
    parameter int PRESC_W  = 16
) (
    input  logic               clk_i,
    input  logic               rst_n_i,
    input  logic [31:0]        wb_adr_i,
    input  logic [31:0]        wb_dat_i,
    input  logic [3:0]         wb_sel_i,
    input  logic               wb_we_i,
    input  logic               wb_cyc_i,
    input  logic               wb_stb_i,
    output logic [31:0]        wb_dat_o,
    output logic               wb_ack_o,
    output logic [NUM_LED-1:0] led_pins
);

    typedef enum logic {
        ST_IDLE,
        ST_ACK
    } state_t;

    state_t state, state_nxt;

    logic [5:0]          adr_idx;
    logic                xfer;
    logic                wr_en;
    logic                duty_hit;
    logic                duty_wr;
    logic [31:0]         wmask;
    logic [31:0]         rdata;
    logic [31:0]         ctrl_wr;

    logic                ctrl_en;
    logic                ctrl_inv;
    logic [PRESC_W-1:0]  presc;
    logic [PRESC_W-1:0]  presc_cnt;
    logic [PWM_BITS-1:0] pwm_cnt;
    logic                pending;
    logic                tick;
    logic                boundary;
    logic [PWM_BITS-1:0] duty   [NUM_LED];
    logic [PWM_BITS-1:0] shadow [NUM_LED];
    logic [NUM_LED-1:0]  raw;

    logic                unused_adr;

    assign adr_idx    = wb_adr_i[7:2];
    assign unused_adr = ^{wb_adr_i[31:8], wb_adr_i[1:0]};
    assign xfer       = (state == ST_IDLE) && wb_cyc_i && wb_stb_i;
    assign wr_en      = xfer && wb_we_i;
    assign duty_wr    = wr_en && duty_hit;
    assign wmask      = {{8{wb_sel_i[3]}}, {8{wb_sel_i[2]}}, {8{wb_sel_i[1]}}, {8{wb_sel_i[0]}}};

    function automatic logic [31:0] merge(input logic [31:0] old_val, input logic [31:0] wd,
                                          input logic [31:0] m);
        return (old_val & ~m) | (wd & m);
    endfunction

    assign ctrl_wr = merge({30'd0, ctrl_inv, ctrl_en}, wb_dat_i, wmask);

    // Handshake FSM
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) state <= ST_IDLE;
        else          state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        wb_ack_o  = 1'b0;
        case (state)
            ST_IDLE: if (wb_cyc_i && wb_stb_i) state_nxt = ST_ACK;
            ST_ACK: begin
                wb_ack_o  = 1'b1;
                state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Address decode and read mux
    always_comb begin
        duty_hit = 1'b0;
        rdata    = '0;
        case (adr_idx)
            6'd0: rdata[1:0] = {ctrl_inv, ctrl_en};
            6'd1: rdata = 32'(presc);
            6'd2: begin
                rdata[PWM_BITS-1:0] = pwm_cnt;
                rdata[31]           = pending;
            end
            default: begin
                for (int unsigned i = 0; i < NUM_LED; i++) begin
                    if (adr_idx == 6'(16 + i)) begin
                        duty_hit = 1'b1;
                        rdata    = 32'(duty[i]);
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i)                 wb_dat_o <= '0;
        else if (xfer && !wb_we_i)    wb_dat_o <= rdata;
        else                          wb_dat_o <= '0;
    end

    // Register file writes, per byte lane
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            ctrl_en  <= 1'b0;
            ctrl_inv <= 1'b0;
            presc    <= '0;
            for (int unsigned i = 0; i < NUM_LED; i++) duty[i] <= '0;
        end else if (wr_en) begin
            if (adr_idx == 6'd0) begin
                {ctrl_inv, ctrl_en} <= ctrl_wr[1:0];
            end
            if (adr_idx == 6'd1) begin
                presc <= PRESC_W'(merge(32'(presc), wb_dat_i, wmask));
            end
            for (int unsigned i = 0; i < NUM_LED; i++) begin
                if (adr_idx == 6'(16 + i)) duty[i] <= PWM_BITS'(merge(32'(duty[i]), wb_dat_i, wmask));
            end
        end
    end

    // >= rather than == so that lowering PRESC below presc_cnt wraps on the next clock
    assign tick     = ctrl_en && (presc_cnt >= presc);
    assign boundary = tick && (pwm_cnt == '1);

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            presc_cnt <= '0;
            pwm_cnt   <= '0;
        end else if (!ctrl_en) begin
            presc_cnt <= '0;
            pwm_cnt   <= '0;
        end else if (tick) begin
            presc_cnt <= '0;
            pwm_cnt   <= pwm_cnt + 1'b1;
        end else begin
            presc_cnt <= presc_cnt + 1'b1;
        end
    end

    // Shadows load from the pre-edge DUTY values, so a coincident write waits for the next load
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            pending <= 1'b0;
            for (int unsigned i = 0; i < NUM_LED; i++) shadow[i] <= '0;
        end else if (!ctrl_en || boundary) begin
            pending <= duty_wr;
            for (int unsigned i = 0; i < NUM_LED; i++) shadow[i] <= duty[i];
        end else if (duty_wr) begin
            pending <= 1'b1;
        end
    end

    always_comb begin
        for (int unsigned i = 0; i < NUM_LED; i++) begin
            raw[i] = (shadow[i] == '1) || (pwm_cnt < shadow[i]);
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i)     led_pins <= '0;
        else if (ctrl_en) led_pins <= raw ^ {NUM_LED{ctrl_inv}};
        else              led_pins <= '0;
    end

endmodule
